// File: rtl/img_rd_arbiter.sv
// img_rd_arbiter
// Shares the single image_buffer read port between N_REQ data fetchers.
// Address requests are granted round-robin. The issuing requester index is pushed into a
// tag FIFO so that each in-order pixel response goes back to whoever asked for it.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   req_addr_valid/ready/addr requester address channels (addr slice i*W_ADDR +: W_ADDR)
//   req_dout_valid/ready      per-requester response handshake
//   req_dout_data             response pixel, shared by all requesters
//   mem_addr_valid/ready/addr address channel towards image_buffer
//   mem_dout_valid/ready/data pixel channel from image_buffer
module img_rd_arbiter #(
    parameter int N_REQ     = 2,
    parameter int W_ADDR    = 17,
    parameter int W_DATA    = 8,
    parameter int MAX_OUTST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_addr_valid,
    output logic [N_REQ-1:0]        req_addr_ready,
    input  logic [N_REQ*W_ADDR-1:0] req_addr,
    output logic [N_REQ-1:0]        req_dout_valid,
    input  logic [N_REQ-1:0]        req_dout_ready,
    output logic [W_DATA-1:0]       req_dout_data,
    output logic                    mem_addr_valid,
    input  logic                    mem_addr_ready,
    output logic [W_ADDR-1:0]       mem_addr,
    input  logic                    mem_dout_valid,
    output logic                    mem_dout_ready,
    input  logic [W_DATA-1:0]       mem_dout_data
);
    localparam int W_IDX = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int W_CNT = $clog2(MAX_OUTST + 1);
    localparam int W_PTR = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [W_CNT-1:0] CNT_FULL = W_CNT'(MAX_OUTST);
    localparam logic [W_IDX-1:0] IDX_LAST = W_IDX'(N_REQ - 1);

    logic [W_IDX-1:0] tag_mem [MAX_OUTST];
    logic [W_PTR-1:0] wr_ptr;
    logic [W_PTR-1:0] rd_ptr;
    logic [W_CNT-1:0] count;
    logic [W_IDX-1:0] rr_ptr;
    logic [W_IDX-1:0] lock_idx;
    logic             lock;

    logic [W_IDX-1:0] gnt_idx;
    logic             gnt_any;
    logic [W_IDX-1:0] head_tag;
    logic             resp_en;
    logic             push;
    logic             pop;
    int               cand;

    // A locked (stalled) grant bypasses arbitration and the full check: count cannot grow
    // while the stalled address is pending, so it was already below the limit.
    always_comb begin
        gnt_idx = rr_ptr;
        gnt_any = 1'b0;
        cand    = 0;
        if (lock) begin
            gnt_idx = lock_idx;
            gnt_any = 1'b1;
        end else if (count < CNT_FULL) begin
            // Walk downwards so the candidate closest to rr_ptr is written last and wins.
            for (int k = N_REQ - 1; k >= 0; k--) begin
                cand = (int'(rr_ptr) + k) % N_REQ;
                if (req_addr_valid[cand]) begin
                    gnt_idx = W_IDX'(cand);
                    gnt_any = 1'b1;
                end
            end
        end
    end

    assign head_tag       = tag_mem[rd_ptr];
    assign resp_en        = rst && (count != '0);
    assign mem_addr_valid = rst && gnt_any && req_addr_valid[gnt_idx];
    assign mem_addr       = req_addr[gnt_idx*W_ADDR +: W_ADDR];
    assign mem_dout_ready = resp_en && req_dout_ready[head_tag];
    assign req_dout_data  = mem_dout_data;

    always_comb begin
        req_addr_ready = '0;
        req_dout_valid = '0;
        if (rst && gnt_any) begin
            req_addr_ready[gnt_idx] = mem_addr_ready;
        end
        if (resp_en) begin
            req_dout_valid[head_tag] = mem_dout_valid;
        end
    end

    assign push = mem_addr_valid && mem_addr_ready;
    assign pop  = mem_dout_valid && mem_dout_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                tag_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= gnt_idx;
                wr_ptr          <= wr_ptr + W_PTR'(1);
                rr_ptr          <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + W_IDX'(1);
                lock            <= 1'b0;
            end else if (mem_addr_valid) begin
                lock     <= 1'b1;
                lock_idx <= gnt_idx;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + W_PTR'(1);
            end
            if (push && !pop) begin
                count <= count + W_CNT'(1);
            end else if (pop && !push) begin
                count <= count - W_CNT'(1);
            end
        end
    end

    a_addr_ready_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(req_addr_ready));
    a_dout_valid_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(req_dout_valid));
    a_addr_stable_in_stall: assert property (@(posedge clk) disable iff (!rst)
        lock |-> $stable(mem_addr));
    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        count <= CNT_FULL);
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst)
        mem_dout_valid |-> (count != '0));

endmodule

// File: tb/tb_img_rd_arbiter.sv
module tb_img_rd_arbiter;
    logic        clk;
    logic        rst;
    logic [1:0]  req_addr_valid;
    logic [1:0]  req_addr_ready;
    logic [33:0] req_addr;
    logic [1:0]  req_dout_valid;
    logic [1:0]  req_dout_ready;
    logic [7:0]  req_dout_data;
    logic        mem_addr_valid;
    logic        mem_addr_ready;
    logic [16:0] mem_addr;
    logic        mem_dout_valid;
    logic        mem_dout_ready;
    logic [7:0]  mem_dout_data;

    img_rd_arbiter #(.N_REQ(2), .W_ADDR(17), .W_DATA(8), .MAX_OUTST(4)) dut (
        .clk(clk), .rst(rst),
        .req_addr_valid(req_addr_valid), .req_addr_ready(req_addr_ready),
        .req_addr(req_addr),
        .req_dout_valid(req_dout_valid), .req_dout_ready(req_dout_ready),
        .req_dout_data(req_dout_data),
        .mem_addr_valid(mem_addr_valid), .mem_addr_ready(mem_addr_ready),
        .mem_addr(mem_addr),
        .mem_dout_valid(mem_dout_valid), .mem_dout_ready(mem_dout_ready),
        .mem_dout_data(mem_dout_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { int id; logic [7:0] data; } sb_t;
    typedef struct { int cyc; logic [7:0] data; } mp_t;

    sb_t         sb[$];
    mp_t         mem_pipe[$];
    int          exp_gnt[$];
    int          rq_cnt[2];
    logic [16:0] rq_addr[2];
    logic        mem_rdy;
    logic [1:0]  rd_rdy;
    logic        mem_en;
    int          cyc_n;
    int          n_assert;
    int          n_fail;
    logic [16:0] held_addr;

    function automatic logic [7:0] pix(input logic [16:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) req_addr_valid[i] = (rq_cnt[i] != 0);
        req_addr       = {rq_addr[1], rq_addr[0]};
        mem_addr_ready = mem_rdy;
        req_dout_ready = rd_rdy;
        if (mem_en && mem_pipe.size() != 0 && mem_pipe[0].cyc < cyc_n) begin
            mem_dout_valid = 1'b1;
            mem_dout_data  = mem_pipe[0].data;
        end else begin
            mem_dout_valid = 1'b0;
            mem_dout_data  = '0;
        end
    endtask

    // Evaluates the handshakes that the coming rising edge will complete.
    task automatic observe();
        int  g;
        int  e;
        sb_t s;
        g = -1;
        for (int i = 0; i < 2; i++) if (req_addr_valid[i] && req_addr_ready[i]) g = i;
        if (g >= 0) begin
            chk("grant_expected", exp_gnt.size() != 0, 1);
            if (exp_gnt.size() != 0) begin
                e = exp_gnt.pop_front();
                chk("grant_idx", g, e);
                sb.push_back('{id: e, data: pix(rq_addr[e])});
            end
            rq_cnt[g]--;
            rq_addr[g] = rq_addr[g] + 17'd1;
        end
        if (mem_addr_valid && mem_addr_ready)
            mem_pipe.push_back('{cyc: cyc_n, data: pix(mem_addr)});
        if (mem_dout_valid && mem_dout_ready && mem_pipe.size() != 0)
            void'(mem_pipe.pop_front());
        if ((req_dout_valid & req_dout_ready) != 2'b00) begin
            chk("resp_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                s = sb.pop_front();
                chk("resp_dest", req_dout_valid, 32'(1 << s.id));
                chk("resp_data", req_dout_data, s.data);
            end
        end
    endtask

    task automatic half();
        drive();
        @(negedge clk);
        observe();
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic tick();
        half();
        fin();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((rq_cnt[0] != 0 || rq_cnt[1] != 0 || sb.size() != 0 || mem_pipe.size() != 0)
               && n < budget) begin
            tick();
            n++;
        end
        chk("idle_reached", (rq_cnt[0] != 0 || rq_cnt[1] != 0 || sb.size() != 0), 0);
        chk("grants_left", exp_gnt.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc_n    = 0;
        rq_cnt[0] = 0;
        rq_cnt[1] = 0;
        rq_addr[0] = 17'h00100;
        rq_addr[1] = 17'h01200;
        mem_rdy  = 1'b1;
        rd_rdy   = 2'b11;
        mem_en   = 1'b1;

        // reset with busy-looking inputs: all outputs must stay quiet
        rst            = 1'b0;
        req_addr_valid = 2'b11;
        req_addr       = '0;
        mem_addr_ready = 1'b1;
        req_dout_ready = 2'b11;
        mem_dout_valid = 1'b1;
        mem_dout_data  = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_addr_valid", mem_addr_valid, 0);
        chk("rst_req_addr_ready", req_addr_ready, 0);
        chk("rst_req_dout_valid", req_dout_valid, 0);
        chk("rst_mem_dout_ready", mem_dout_ready, 0);
        chk("rst_count", dut.count, 0);
        drive();
        rst = 1'b1;
        fin();

        // 1: both requesters busy, grants alternate
        rq_cnt[0] = 4; rq_cnt[1] = 4;
        exp_gnt = '{0, 1, 0, 1, 0, 1, 0, 1};
        wait_idle(60);

        // 2: only req1, then both with rr_ptr back at 0
        rq_cnt[1] = 5;
        exp_gnt = '{1, 1, 1, 1, 1};
        wait_idle(40);
        rq_cnt[0] = 1; rq_cnt[1] = 1;
        exp_gnt = '{0, 1};
        wait_idle(20);

        // 3: stall with req0 granted; rr_ptr first moved to 1 so a lost lock would re-grant
        rq_cnt[0] = 1;
        exp_gnt = '{0};
        wait_idle(20);
        mem_rdy = 1'b0;
        rq_cnt[0] = 1;
        held_addr = rq_addr[0];
        half();
        chk("stall_valid_c1", mem_addr_valid, 1);
        chk("stall_addr_c1", mem_addr, held_addr);
        chk("stall_ready_c1", req_addr_ready, 0);
        fin();
        rq_cnt[1] = 1;
        for (int c = 0; c < 2; c++) begin
            half();
            chk("stall_valid", mem_addr_valid, 1);
            chk("stall_addr", mem_addr, held_addr);
            chk("stall_ready", req_addr_ready, 0);
            fin();
        end
        mem_rdy = 1'b1;
        exp_gnt = '{0, 1};
        wait_idle(20);

        // 4: responses held back until the tag FIFO is full
        mem_en = 1'b0;
        rq_cnt[0] = 3; rq_cnt[1] = 2;
        exp_gnt = '{0, 1, 0, 1, 0};
        repeat (4) tick();
        half();
        chk("full_mem_addr_valid", mem_addr_valid, 0);
        chk("full_req_addr_ready", req_addr_ready, 0);
        fin();
        mem_en = 1'b1;
        half();
        chk("full_pop_mem_dout_ready", mem_dout_ready, 1);
        chk("full_pop_no_issue", req_addr_ready, 0);
        fin();
        half();
        chk("after_pop_issue", req_addr_ready, 2'b01);
        fin();
        wait_idle(40);

        // 5: req0 response at head, req0 not ready
        mem_en = 1'b0;
        rq_cnt[0] = 1;
        exp_gnt = '{0};
        tick();
        rq_cnt[1] = 1;
        exp_gnt.push_back(1);
        tick();
        tick();
        rd_rdy = 2'b10;
        mem_en = 1'b1;
        for (int c = 0; c < 2; c++) begin
            half();
            chk("bp_dout_valid", req_dout_valid, 2'b01);
            chk("bp_mem_dout_ready", mem_dout_ready, 0);
            fin();
        end
        rd_rdy = 2'b11;
        wait_idle(20);

        // 6: reset with three reads outstanding
        mem_en = 1'b0;
        rq_cnt[0] = 2; rq_cnt[1] = 1;
        exp_gnt = '{0, 1, 0};
        repeat (3) tick();
        chk("pre_rst_count", dut.count, 3);
        rst = 1'b0;
        sb.delete();
        mem_pipe.delete();
        exp_gnt.delete();
        rq_cnt[0] = 1; rq_cnt[1] = 1;
        mem_en = 1'b1;
        drive();
        #1;
        chk("rst6_count", dut.count, 0);
        chk("rst6_mem_addr_valid", mem_addr_valid, 0);
        chk("rst6_req_addr_ready", req_addr_ready, 0);
        chk("rst6_req_dout_valid", req_dout_valid, 0);
        repeat (2) tick();
        rst = 1'b1;
        exp_gnt = '{0, 1};
        wait_idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
